// File: rtl/obi_mem_arbiter.sv
// obi_mem_arbiter: shares one OBI memory port between instr and data masters.
// Define MEM_ARB_FIXED_PRIO_EN to make data win every conflict.
module obi_mem_arbiter #(
   parameter int ADDR_WIDTH_BIT  = 32,
   parameter int DATA_WIDTH_BIT  = 32,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        instr_req_i,
   output logic                        instr_gnt_o,
   input  logic [ADDR_WIDTH_BIT-1:0]   instr_addr_i,
   input  logic                        instr_we_i,
   input  logic [DATA_WIDTH_BIT/8-1:0] instr_be_i,
   input  logic [DATA_WIDTH_BIT-1:0]   instr_wdata_i,
   output logic                        instr_rvalid_o,
   output logic [DATA_WIDTH_BIT-1:0]   instr_rdata_o,
   input  logic                        data_req_i,
   output logic                        data_gnt_o,
   input  logic [ADDR_WIDTH_BIT-1:0]   data_addr_i,
   input  logic                        data_we_i,
   input  logic [DATA_WIDTH_BIT/8-1:0] data_be_i,
   input  logic [DATA_WIDTH_BIT-1:0]   data_wdata_i,
   output logic                        data_rvalid_o,
   output logic [DATA_WIDTH_BIT-1:0]   data_rdata_o,
   output logic                        mem_req_o,
   input  logic                        mem_gnt_i,
   output logic [ADDR_WIDTH_BIT-1:0]   mem_addr_o,
   output logic                        mem_we_o,
   output logic [DATA_WIDTH_BIT/8-1:0] mem_be_o,
   output logic [DATA_WIDTH_BIT-1:0]   mem_wdata_o,
   input  logic                        mem_rvalid_i,
   input  logic [DATA_WIDTH_BIT-1:0]   mem_rdata_i,
   output logic                        err_o
);

   localparam int PW = $clog2(MAX_OUTSTANDING);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH = CW'(MAX_OUTSTANDING);

   typedef enum logic {
      S_OPEN,
      S_LOCK
   } lock_state_t;

   lock_state_t state_q, state_d;
   logic lock_src_q, lock_src_d;
   logic rr_last_q;
   logic [MAX_OUTSTANDING-1:0] src_fifo_q;
   logic [PW-1:0] rptr_q, wptr_q;
   logic [CW-1:0] count_q;
   logic err_q;

   logic locked, both, arb_both;
   logic sel, sel_req, issue, hs;
   logic full, empty, pop, spurious, head;

   assign locked = (state_q == S_LOCK);
   assign both   = instr_req_i & data_req_i;

`ifdef MEM_ARB_FIXED_PRIO_EN
   assign arb_both = 1'b1;
`else
   assign arb_both = ~rr_last_q;
`endif

   always_comb begin
      unique case (1'b1)
         locked:           sel = lock_src_q;
         !locked && both:  sel = arb_both;
         !locked && !both: sel = data_req_i;
         default:          sel = 1'b0;
      endcase
   end

   // full uses the pre-pop count: a same-cycle response never frees a slot
   assign full     = (count_q == DEPTH);
   assign empty    = (count_q == '0);
   assign sel_req  = sel ? data_req_i : instr_req_i;
   assign issue    = ~full & sel_req;
   assign hs       = issue & mem_gnt_i;
   assign pop      = mem_rvalid_i & ~empty;
   assign spurious = mem_rvalid_i & empty;
   assign head     = src_fifo_q[rptr_q];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= S_OPEN;
         lock_src_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         lock_src_q <= lock_src_d;
      end
   end

   // a locked master that drops req releases the lock without error
   always_comb begin
      state_d    = state_q;
      lock_src_d = lock_src_q;
      unique case (state_q)
         S_OPEN: begin
            if (issue && !mem_gnt_i) begin
               state_d    = S_LOCK;
               lock_src_d = sel;
            end
         end
         S_LOCK: begin
            if (hs || !sel_req) state_d = S_OPEN;
         end
         default: state_d = S_OPEN;
      endcase
   end

   always_comb begin
      mem_req_o      = 1'b0;
      instr_gnt_o    = 1'b0;
      data_gnt_o     = 1'b0;
      mem_addr_o     = '0;
      mem_we_o       = 1'b0;
      mem_be_o       = '0;
      mem_wdata_o    = '0;
      instr_rvalid_o = 1'b0;
      data_rvalid_o  = 1'b0;
      if (issue && !rst_i) begin
         mem_req_o   = 1'b1;
         instr_gnt_o = hs & ~sel;
         data_gnt_o  = hs & sel;
         mem_addr_o  = sel ? data_addr_i : instr_addr_i;
         mem_we_o    = sel ? data_we_i : instr_we_i;
         mem_be_o    = sel ? data_be_i : instr_be_i;
         mem_wdata_o = sel ? data_wdata_i : instr_wdata_i;
      end
      if (pop && !rst_i) begin
         instr_rvalid_o = ~head;
         data_rvalid_o  = head;
      end
   end

   assign instr_rdata_o = rst_i ? '0 : mem_rdata_i;
   assign data_rdata_o  = rst_i ? '0 : mem_rdata_i;
   assign err_o         = err_q & ~rst_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_last_q  <= 1'b1;
         src_fifo_q <= '0;
         rptr_q     <= '0;
         wptr_q     <= '0;
         count_q    <= '0;
         err_q      <= 1'b0;
      end else begin
         if (hs) begin
            src_fifo_q[wptr_q] <= sel;
            wptr_q             <= wptr_q + PW'(1);
            rr_last_q          <= sel;
         end
         if (pop) rptr_q <= rptr_q + PW'(1);
         if (hs && !pop) count_q <= count_q + CW'(1);
         else if (!hs && pop) count_q <= count_q - CW'(1);
         if (spurious) err_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// tb_obi_mem_arbiter: directed plan scenarios plus random traffic
// checked every cycle against a queue-based reference model.
module tb_obi_mem_arbiter;

`ifdef MEM_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif
   localparam int DEPTH = 4;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   logic instr_req_i = 0, data_req_i = 0;
   logic instr_gnt_o, data_gnt_o;
   logic [31:0] instr_addr_i = 0, data_addr_i = 0;
   logic instr_we_i = 0, data_we_i = 0;
   logic [3:0] instr_be_i = 0, data_be_i = 0;
   logic [31:0] instr_wdata_i = 0, data_wdata_i = 0;
   logic instr_rvalid_o, data_rvalid_o;
   logic [31:0] instr_rdata_o, data_rdata_o;
   logic mem_req_o;
   logic mem_gnt_i = 0;
   logic [31:0] mem_addr_o;
   logic mem_we_o;
   logic [3:0] mem_be_o;
   logic [31:0] mem_wdata_o;
   logic mem_rvalid_i = 0;
   logic [31:0] mem_rdata_i = 0;
   logic err_o;

   always #5 clk_i = ~clk_i;

   obi_mem_arbiter dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .instr_req_i(instr_req_i), .instr_gnt_o(instr_gnt_o),
      .instr_addr_i(instr_addr_i), .instr_we_i(instr_we_i),
      .instr_be_i(instr_be_i), .instr_wdata_i(instr_wdata_i),
      .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
      .data_req_i(data_req_i), .data_gnt_o(data_gnt_o),
      .data_addr_i(data_addr_i), .data_we_i(data_we_i),
      .data_be_i(data_be_i), .data_wdata_i(data_wdata_i),
      .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
      .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i),
      .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
      .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
      .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
      .err_o(err_o)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // reference model: FIFO of issuing sources plus arbitration state
   bit q[$];
   bit m_rr = 1'b1, m_lock = 1'b0, m_lsrc = 1'b0, m_err = 1'b0;

   logic [31:0] ia = 0, da = 0, iwd = 0, dwd = 0;
   logic [3:0] ibe = 0, dbe = 0;
   logic iwe = 0, dwe = 0;

   logic o_req, o_ign, o_dgn, o_irv, o_drv, o_err;
   logic [31:0] o_addr, o_ird;

   task automatic cyc(input bit ir, input bit dr, input bit gnt,
                      input bit rv, input bit rst, input logic [31:0] rd);
      bit sel, sreq, req, hs, pop, spur, hd, ok;
      @(negedge clk_i);
      rst_i = rst;
      instr_req_i = ir; data_req_i = dr;
      mem_gnt_i = gnt; mem_rvalid_i = rv; mem_rdata_i = rd;
      instr_addr_i = ia; data_addr_i = da;
      instr_we_i = iwe; data_we_i = dwe;
      instr_be_i = ibe; data_be_i = dbe;
      instr_wdata_i = iwd; data_wdata_i = dwd;
      #1;
      if (m_lock) sel = m_lsrc;
      else if (ir && dr) sel = FIXED ? 1'b1 : !m_rr;
      else sel = dr;
      sreq = sel ? dr : ir;
      req  = (q.size() < DEPTH) && sreq;
      hs   = req && gnt;
      pop  = rv && (q.size() != 0);
      spur = rv && (q.size() == 0);
      hd   = pop ? q[0] : 1'b0;
      ok   = !rst && req;
      check("mem_req", mem_req_o, ok);
      check("mem_addr", mem_addr_o, ok ? (sel ? da : ia) : 32'h0);
      check("mem_we", mem_we_o, ok ? (sel ? dwe : iwe) : 1'b0);
      check("mem_be", mem_be_o, ok ? (sel ? dbe : ibe) : 4'h0);
      check("mem_wdata", mem_wdata_o, ok ? (sel ? dwd : iwd) : 32'h0);
      check("instr_gnt", instr_gnt_o, ok && hs && !sel);
      check("data_gnt", data_gnt_o, ok && hs && sel);
      check("instr_rvalid", instr_rvalid_o, !rst && pop && !hd);
      check("data_rvalid", data_rvalid_o, !rst && pop && hd);
      check("instr_rdata", instr_rdata_o, rst ? 32'h0 : rd);
      check("data_rdata", data_rdata_o, rst ? 32'h0 : rd);
      check("err", err_o, !rst && m_err);
      o_req = mem_req_o; o_ign = instr_gnt_o; o_dgn = data_gnt_o;
      o_irv = instr_rvalid_o; o_drv = data_rvalid_o; o_err = err_o;
      o_addr = mem_addr_o; o_ird = instr_rdata_o;
      @(posedge clk_i);
      if (rst) begin
         q.delete();
         m_rr = 1'b1; m_lock = 1'b0; m_lsrc = 1'b0; m_err = 1'b0;
      end else begin
         if (spur) m_err = 1'b1;
         if (pop) hd = q.pop_front();
         if (hs) begin
            q.push_back(sel);
            m_rr = sel;
            m_lock = 1'b0;
         end else if (req) begin
            m_lock = 1'b1;
            m_lsrc = sel;
         end else begin
            m_lock = 1'b0;
         end
      end
   endtask

   task automatic do_reset();
      cyc(0, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 1, 0);
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 1, 0, 32'h1000 + i);
   endtask

   initial begin
      do_reset();
      check("rst_err", o_err, 1'b0);
      check("rst_req", o_req, 1'b0);

      // instr-only request
      ia = 32'h100;
      cyc(1, 0, 1, 0, 0, 0);
      check("io_gnt", o_ign, 1'b1);
      check("io_addr", o_addr, 32'h100);
      cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 32'hDEADBEEF);
      check("io_rvalid", o_irv, 1'b1);
      check("io_rdata", o_ird, 32'hDEADBEEF);
      check("io_drvalid", o_drv, 1'b0);

      // conflict after reset
      do_reset();
      ia = 32'h10; da = 32'h20;
      for (int k = 0; k < 4; k++) begin
         cyc(1, 1, 1, 0, 0, 0);
         check("conf_addr", o_addr,
               FIXED ? 32'h20 : ((k % 2) ? 32'h20 : 32'h10));
      end
      cyc(0, 0, 0, 1, 0, 32'hA);
      check("conf_a_instr", o_irv, !FIXED);
      check("conf_a_data", o_drv, FIXED);
      cyc(0, 0, 0, 1, 0, 32'hB);
      check("conf_b_data", o_drv, 1'b1);
      drain(2);

      // grant stall
      do_reset();
      for (int k = 0; k < 3; k++) begin
         cyc(1, 1, 0, 0, 0, 0);
         check("stall_addr", o_addr, FIXED ? 32'h20 : 32'h10);
      end
      cyc(1, 1, 1, 0, 0, 0);
      check("stall_gaddr", o_addr, FIXED ? 32'h20 : 32'h10);
      check("stall_ign", o_ign, !FIXED);
      cyc(1, 1, 1, 0, 0, 0);
      check("stall_next", o_addr, 32'h20);
      drain(2);

      // FIFO full
      do_reset();
      for (int k = 0; k < 4; k++) cyc(1, 0, 1, 0, 0, 0);
      cyc(1, 0, 1, 0, 0, 0);
      check("full_req", o_req, 1'b0);
      check("full_gnt", o_ign, 1'b0);
      cyc(1, 0, 1, 1, 0, 32'h77);
      check("full_popreq", o_req, 1'b0);
      check("full_pop", o_irv, 1'b1);
      cyc(1, 0, 1, 0, 0, 0);
      check("full_issue", o_ign, 1'b1);
      drain(4);

      // spurious response
      do_reset();
      cyc(0, 0, 0, 1, 0, 32'h55);
      check("spur_irv", o_irv, 1'b0);
      check("spur_drv", o_drv, 1'b0);
      for (int k = 0; k < 3; k++) begin
         cyc(0, 0, 0, 0, 0, 0);
         check("spur_err", o_err, 1'b1);
      end

      // reset mid-flight
      do_reset();
      check("rst_clr_err", o_err, 1'b0);
      cyc(1, 0, 1, 0, 0, 0);
      cyc(1, 0, 1, 0, 0, 0);
      cyc(1, 1, 1, 1, 1, 32'h99);
      check("mid_req", o_req, 1'b0);
      check("mid_rvalid", o_irv, 1'b0);
      check("mid_addr", o_addr, 32'h0);
      check("mid_rdata", o_ird, 32'h0);
      cyc(0, 0, 0, 1, 0, 32'h99);
      check("mid_drop", o_irv, 1'b0);
      cyc(0, 0, 0, 0, 0, 0);
      check("mid_err", o_err, 1'b1);

      // random traffic
      do_reset();
      for (int k = 0; k < 3000; k++) begin
         ia = $urandom; da = $urandom;
         iwd = $urandom; dwd = $urandom;
         ibe = 4'($urandom); dbe = 4'($urandom);
         iwe = 1'($urandom); dwe = 1'($urandom);
         cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
             $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
             $urandom_range(0, 99) == 0, $urandom);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/obi_mem_arbiter.md
# obi_mem_arbiter

Shares one OBI memory port between the instruction-side and data-side OBI masters of the cache hierarchy, downstream of the two vx_mem_to_obi_bridge instances. It arbitrates requests and holds the selection stable until grant, as OBI requires. It tracks outstanding transactions in an in-order source FIFO and routes each response back to its issuing master. A sticky error flag reports responses that arrive with no transaction outstanding.

## Interface
- ADDR_WIDTH_BIT, 32, address width
- DATA_WIDTH_BIT, 32, data width; byte-enable width is DATA_WIDTH_BIT/8
- MAX_OUTSTANDING, 4, source-FIFO depth; power of two, ≥2

- clk_i  in  1  clock; all state on rising edge
- rst_i  in  1  reset; synchronous, active-high
- {instr,data}_req_i  in  1  master request
- {instr,data}_gnt_o  out  1  master grant
- {instr,data}_addr_i  in  ADDR_WIDTH_BIT  address
- {instr,data}_we_i  in  1  write enable
- {instr,data}_be_i  in  DATA_WIDTH_BIT/8  byte enables
- {instr,data}_wdata_i  in  DATA_WIDTH_BIT  write data
- {instr,data}_rvalid_o  out  1  response valid for that master
- {instr,data}_rdata_o  out  DATA_WIDTH_BIT  response data, broadcast mem_rdata_i
- mem_req_o  out  1  shared-port request
- mem_gnt_i  in  1  shared-port grant
- mem_addr_o / mem_we_o / mem_be_o / mem_wdata_o  out  as above  muxed from selected master
- mem_rvalid_i  in  1  shared-port response valid
- mem_rdata_i  in  DATA_WIDTH_BIT  shared-port response data
- err_o  out  1  sticky protocol error

## Operation
- State:
  - `lock` (1b) and `lock_src` (1b; 0 = instr, 1 = data).
  - `rr_last` (1b): last granted source.
  - Source FIFO: MAX_OUTSTANDING × 1b, with read pointer, write pointer and `count` ($clog2(MAX_OUTSTANDING)+1 bits).
  - `err_o`.
- `full` = (count == MAX_OUTSTANDING).
- Selection:
  - If `lock`, sel = lock_src.
  - Otherwise, if only one master requests, sel is that master.
  - If both request, sel = !rr_last.
- mem_req_o = !full && (sel master's req_i). While mem_req_o=0, mem_addr_o/we/be/wdata are driven 0.
- Handshake is `hs` = mem_req_o && mem_gnt_i:
  - sel master's gnt_o = hs; the other master's gnt_o = 0.
  - On hs: push sel into the FIFO, rr_last ← sel, lock ← 0.
- mem_req_o && !mem_gnt_i sets lock ← 1 and lock_src ← sel. The selection cannot switch before grant.
- If the locked master drops req_i (OBI violation), lock clears the next cycle. No error is raised.
- Responses:
  - On mem_rvalid_i with count>0: pop the FIFO and assert the head source's rvalid_o the same cycle.
  - On mem_rvalid_i with count==0: no rvalid_o is asserted, and err_o ← 1 (sticky until reset).
- Simultaneous push and pop: count unchanged, both pointers advance.
- `full` is evaluated on the pre-pop count, so no push is allowed when full even if a pop occurs in the same cycle.
- Pointers wrap modulo MAX_OUTSTANDING.

## Timing
- Request path and response path are both combinational: zero added latency.
- Reset values:
  - All outputs 0.
  - lock=0, rr_last=1 (instr wins the first conflict), FIFO empty, err_o=0.
- Reset mid-operation discards all outstanding entries. Any response arriving after reset hits an empty FIFO, is dropped, and sets err_o.
- Throughput: one issue per cycle while not full, and one response per cycle.

## Configuration
- MEM_ARB_FIXED_PRIO_EN:
  - Defined: on conflict, data always wins (sel = 1). rr_last is still updated but does not affect selection. Instr can starve while data requests continuously.
  - Undefined (default): round-robin as above.
- Lock behaviour is identical in both modes.

## Test plan
- Instr-only request:
  - Stimulus: instr_req_i=1, addr 0x100; mem_gnt_i=1 in the same cycle; mem_rvalid_i two cycles later with rdata 0xDEADBEEF.
  - Required: instr_gnt_o=1 in the request cycle, mem_addr_o=0x100, instr_rvalid_o=1 with 0xDEADBEEF, data_rvalid_o=0.
- Conflict after reset:
  - Stimulus: both masters request continuously (instr 0x10, data 0x20); mem_gnt_i always 1; responses 0xA then 0xB.
  - Required: issue order is instr, data, instr, data; 0xA is routed to instr and 0xB to data. With the macro defined, data is granted every cycle.
- Grant stall:
  - Stimulus: both masters request; mem_gnt_i=0 for 3 cycles.
  - Required: mem_addr_o holds 0x10 (instr) in all 3 cycles; it switches to 0x20 only after the grant cycle.
- FIFO full:
  - Stimulus: 4 instr transactions granted with no responses, then a 5th request.
  - Required: mem_req_o=0 and instr_gnt_o=0 for the 5th. One mem_rvalid_i pops an entry; the 5th request is issued the following cycle.
- Spurious response:
  - Stimulus: mem_rvalid_i=1 with the FIFO empty.
  - Required: both rvalid_o stay 0; err_o=1 and remains set until rst_i.
- Reset mid-flight:
  - Stimulus: 2 transactions outstanding, then rst_i for 1 cycle, then mem_rvalid_i.
  - Required: all outputs are 0 during reset; the post-reset rvalid is dropped and err_o=1.
